// File: rtl/ber_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// ber_sweep_ctrl
//
// Sequences a bit-error-rate sweep over a range of SNR points. For each point
// the LLR buffers are flushed, then frames are repeatedly captured into the
// decoder and decoded until either the frame limit or the frame-error target
// is reached. The per-point result is offered on a valid/ready handshake.
// After the last point the controller parks in DONE.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle pulse, accepted only in IDLE/DONE
//   snr_first, snr_last       inclusive sweep bounds (captured at start)
//   max_frames, min_errs      per-point frame limit / error target (captured)
//   frame_ready               all noise/LLR buffers full
//   term, frame_err           decoder finished / finished frame in error
//   snr_idx                   SNR index driven to the quantizers
//   buf_flush                 clear LLR buffers
//   llr_load                  strobe: capture buffers into decoder input reg
//   dec_rst, dec_en           decoder reset / enable
//   res_valid, res_ready      per-point result handshake
//   res_snr, res_frames,
//   res_errs                  per-point result payload
//   busy, done                sweep running / sweep complete
//   tmo_cnt                   decode timeouts (only with BER_WATCHDOG_EN)
//
// Build option
//   BER_WATCHDOG_EN  when defined, a decode watchdog aborts a frame after
//                    TMO_CYC cycles without term, counts it as a frame in
//                    error, and adds the tmo_cnt output.
//
// States
//   IDLE   | waiting for start after reset
//   SETTLE | SNR index just changed, flushing buffers for SETTLE_CYC cycles
//   FILL   | waiting for all buffers to fill
//   LOAD   | one cycle: capture buffers, reset decoder, start next refill
//   DECODE | decoder running, waiting for term
//   REPORT | result offered, waiting for res_ready
//   DONE   | sweep complete, waiting for start
// ---------------------------------------------------------------------------
module ber_sweep_ctrl #(
  parameter int unsigned SNR_W      = 4,
  parameter int unsigned FRM_W      = 16,
  parameter int unsigned ERR_W      = 12,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned TMO_CYC    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SNR_W-1:0] snr_first,
  input  logic [SNR_W-1:0] snr_last,
  input  logic [FRM_W-1:0] max_frames,
  input  logic [ERR_W-1:0] min_errs,
  input  logic             frame_ready,
  input  logic             term,
  input  logic             frame_err,
  output logic [SNR_W-1:0] snr_idx,
  output logic             buf_flush,
  output logic             llr_load,
  output logic             dec_rst,
  output logic             dec_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SNR_W-1:0] res_snr,
  output logic [FRM_W-1:0] res_frames,
  output logic [ERR_W-1:0] res_errs,
  output logic             busy,
  output logic             done
`ifdef BER_WATCHDOG_EN
  ,
  output logic [ERR_W-1:0] tmo_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FILL,
    LOAD,
    DECODE,
    REPORT,
    DONE
  } state_t;

  localparam int unsigned      SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);
  localparam logic [FRM_W-1:0] FRM_MAX   = '1;
  localparam logic [FRM_W-1:0] FRM_ONE   = FRM_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t state, state_nx;

  logic [SNR_W-1:0] snr_last_q;
  logic [FRM_W-1:0] max_frm_q;
  logic [ERR_W-1:0] min_errs_q;
  logic [FRM_W-1:0] frames_q;
  logic [ERR_W-1:0] errs_q;
  logic [SET_W-1:0] settle_cnt;
  logic             dec_rst_hold;

  logic             sweep_ld;
  logic             pt_next;
  logic             frm_done;
  logic             frm_bad;
  logic             tmo_hit;
  logic [FRM_W-1:0] frames_inc;
  logic [ERR_W-1:0] errs_inc;
  logic [ERR_W-1:0] errs_upd;
  logic             pt_full;

  // ---------------------------------------------------------------------
  // Decode watchdog
  // ---------------------------------------------------------------------
`ifdef BER_WATCHDOG_EN
  localparam int unsigned      WDT_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [WDT_W-1:0] WDT_LD = WDT_W'(TMO_CYC - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // A term arriving in the same cycle as the timeout wins.
  assign tmo_hit = (state == DECODE) && !term && (wdt_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= WDT_LD;
      tmo_cnt <= '0;
    end else begin
      if (state == LOAD) begin
        wdt_cnt <= WDT_LD;
      end else if ((state == DECODE) && (wdt_cnt != '0)) begin
        wdt_cnt <= wdt_cnt - 1'b1;
      end
      if (tmo_hit && (tmo_cnt != ERR_MAX)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Frame bookkeeping
  // ---------------------------------------------------------------------
  assign frm_done = (state == DECODE) && (term || tmo_hit);
  assign frm_bad  = (state == DECODE) && ((term && frame_err) || tmo_hit);

  assign frames_inc = (frames_q == FRM_MAX) ? frames_q : frames_q + 1'b1;
  assign errs_inc   = (errs_q == ERR_MAX) ? errs_q : errs_q + 1'b1;
  assign errs_upd   = frm_bad ? errs_inc : errs_q;

  // Evaluated on the counts as they will be after this frame. A saturated
  // frame counter also closes the point so the result is never ambiguous.
  assign pt_full = (frames_inc == max_frm_q) ||
                   (frames_inc == FRM_MAX)   ||
                   (errs_upd >= min_errs_q);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sweep_ld  = 1'b0;
    pt_next   = 1'b0;
    buf_flush = 1'b0;
    llr_load  = 1'b0;
    dec_en    = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = SETTLE;
          sweep_ld = 1'b1;
        end
      end

      SETTLE: begin
        buf_flush = 1'b1;
        if (settle_cnt == '0) begin
          state_nx = FILL;
        end
      end

      FILL: begin
        if (frame_ready) begin
          state_nx = LOAD;
        end
      end

      LOAD: begin
        // Flushing here lets the buffers refill while the decoder runs.
        llr_load  = 1'b1;
        buf_flush = 1'b1;
        state_nx  = DECODE;
      end

      DECODE: begin
        dec_en = 1'b1;
        if (frm_done) begin
          state_nx = pt_full ? REPORT : FILL;
        end
      end

      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          // '>=' also ends a sweep whose first bound exceeds the last.
          if (snr_idx >= snr_last_q) begin
            state_nx = DONE;
          end else begin
            state_nx = SETTLE;
            pt_next  = 1'b1;
          end
        end
      end

      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          state_nx = SETTLE;
          sweep_ld = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // dec_rst is held from reset until the first frame is loaded, then only
  // pulses on LOAD (and on a watchdog abort).
  assign dec_rst = dec_rst_hold || (state == LOAD) || tmo_hit;

  assign res_snr    = snr_idx;
  assign res_frames = frames_q;
  assign res_errs   = errs_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      snr_idx      <= '0;
      snr_last_q   <= '0;
      max_frm_q    <= FRM_ONE;
      min_errs_q   <= '0;
      frames_q     <= '0;
      errs_q       <= '0;
      settle_cnt   <= SETTLE_LD;
      dec_rst_hold <= 1'b1;
    end else begin
      if (sweep_ld) begin
        snr_idx    <= snr_first;
        snr_last_q <= snr_last;
        max_frm_q  <= (max_frames == '0) ? FRM_ONE : max_frames;
        min_errs_q <= min_errs;
        frames_q   <= '0;
        errs_q     <= '0;
      end else if (pt_next) begin
        snr_idx  <= snr_idx + 1'b1;
        frames_q <= '0;
        errs_q   <= '0;
      end else if (frm_done) begin
        frames_q <= frames_inc;
        errs_q   <= errs_upd;
      end

      if (sweep_ld || pt_next) begin
        settle_cnt <= SETTLE_LD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end

      if (state == LOAD) begin
        dec_rst_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ber_sweep_ctrl
//
// Drives ber_sweep_ctrl with directed and randomized sweeps. A simple
// decoder model answers each llr_load with term after a random delay, using
// a per-sweep table of frame-error bits. The expected per-point results are
// computed up front from that table by walking the sweep rules directly.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ber_sweep_ctrl;

  localparam int SNR_W      = 4;
  localparam int FRM_W      = 16;
  localparam int ERR_W      = 12;
  localparam int SETTLE_CYC = 16;
`ifdef BER_WATCHDOG_EN
  localparam int TMO_CYC    = 8;
`else
  localparam int TMO_CYC    = 4096;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SNR_W-1:0] snr_first;
  logic [SNR_W-1:0] snr_last;
  logic [FRM_W-1:0] max_frames;
  logic [ERR_W-1:0] min_errs;
  logic             frame_ready;
  logic             term;
  logic             frame_err;
  logic [SNR_W-1:0] snr_idx;
  logic             buf_flush;
  logic             llr_load;
  logic             dec_rst;
  logic             dec_en;
  logic             res_valid;
  logic             res_ready;
  logic [SNR_W-1:0] res_snr;
  logic [FRM_W-1:0] res_frames;
  logic [ERR_W-1:0] res_errs;
  logic             busy;
  logic             done;
`ifdef BER_WATCHDOG_EN
  logic [ERR_W-1:0] tmo_cnt;
`endif

  always #5 clk = ~clk;

  ber_sweep_ctrl #(
    .SNR_W     (SNR_W),
    .FRM_W     (FRM_W),
    .ERR_W     (ERR_W),
    .SETTLE_CYC(SETTLE_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .snr_first  (snr_first),
    .snr_last   (snr_last),
    .max_frames (max_frames),
    .min_errs   (min_errs),
    .frame_ready(frame_ready),
    .term       (term),
    .frame_err  (frame_err),
    .snr_idx    (snr_idx),
    .buf_flush  (buf_flush),
    .llr_load   (llr_load),
    .dec_rst    (dec_rst),
    .dec_en     (dec_en),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_snr    (res_snr),
    .res_frames (res_frames),
    .res_errs   (res_errs),
    .busy       (busy),
    .done       (done)
`ifdef BER_WATCHDOG_EN
    ,
    .tmo_cnt    (tmo_cnt)
`endif
  );

  typedef struct {
    int snr;
    int frames;
    int errs;
  } res_t;

  res_t exp_q[$];
  bit   pat[64];
  bit   hold_flag;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk the sweep rules over the frame-error table.
  function automatic void build_exp(input int first, input int last,
                                    input int maxf, input int mine);
    int s, k, f, e, mf;
    s  = first;
    k  = 0;
    mf = (maxf == 0) ? 1 : maxf;
    exp_q.delete();
    forever begin
      f = 0;
      e = 0;
      do begin
        e += int'(pat[k]);
        k++;
        f++;
      end while (!(f == mf || e >= mine));
      exp_q.push_back('{s, f, e});
      if (s >= last) break;
      s++;
    end
  endfunction

  task automatic drive_quiet();
    start       = 1'b0;
    term        = 1'b0;
    frame_err   = 1'b0;
    res_ready   = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_buf_flush"},  buf_flush,  0);
    chk({tag, "_llr_load"},   llr_load,   0);
    chk({tag, "_dec_en"},     dec_en,     0);
    chk({tag, "_dec_rst"},    dec_rst,    1);
    chk({tag, "_res_valid"},  res_valid,  0);
    chk({tag, "_snr_idx"},    snr_idx,    0);
    chk({tag, "_res_snr"},    res_snr,    0);
    chk({tag, "_res_frames"}, res_frames, 0);
    chk({tag, "_res_errs"},   res_errs,   0);
`ifdef BER_WATCHDOG_EN
    chk({tag, "_tmo_cnt"},    tmo_cnt,    0);
`endif
  endtask

  // pmode: 0 all frames clean, 1 all frames in error, 2 random.
  // hold: cycles res_ready stays low per result (-1 = random 0..3).
  // rst_at: pulse rst during DECODE of this frame number (0 = never).
  task automatic run_sweep(input int first, input int last, input int maxf,
                           input int mine, input int pmode, input int hold,
                           input int rst_at);
    int run = 0;
    int k = 0;
    int n_load = 0;
    int dec_wait = 0;
    int rr_wait = 0;
    bit dec_pend = 0;
    bit term_prev = 0;
    bit xfer_prev = 0;
    bit valid_prev = 0;
    bit in_rst = 0;
    bit finished = 0;

    for (int i = 0; i < 64; i++) begin
      pat[i] = (pmode == 2) ? bit'($urandom % 2) : (pmode == 1);
    end
    build_exp(first, last, maxf, mine);

    @(negedge clk);
    snr_first  = SNR_W'(first);
    snr_last   = SNR_W'(last);
    max_frames = FRM_W'(maxf);
    min_errs   = ERR_W'(mine);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_snr", snr_idx, first);
    snr_first  = SNR_W'($urandom);
    snr_last   = SNR_W'($urandom);
    max_frames = FRM_W'($urandom);
    min_errs   = ERR_W'($urandom);

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (in_rst) begin
        chk_reset_vals("mid_rst");
        rst       = 1'b0;
        hold_flag = 1'b1;
        drive_quiet();
        return;
      end

      if (buf_flush && !llr_load) begin
        run++;
      end else begin
        if (run != 0) chk("settle_len", run, SETTLE_CYC);
        run = 0;
      end

      chk("dec_rst", dec_rst, int'(llr_load | hold_flag));
      if (llr_load) hold_flag = 1'b0;

      if (term_prev) chk("dec_en_drop", dec_en, 0);
      term_prev = 1'b0;

      if (xfer_prev) begin
        if (exp_q.size() != 0) begin
          chk("resume_settle", {busy, buf_flush}, 3);
        end else begin
          chk("sweep_done", {busy, done}, 1);
          finished = 1'b1;
        end
      end
      xfer_prev = 1'b0;

      if (!finished) begin
        start       = 1'b0;
        term        = 1'b0;
        frame_err   = bit'($urandom % 2);
        frame_ready = ($urandom % 4) != 0;
        if (busy && ($urandom % 16) == 0) start = 1'b1;

        if (llr_load && exp_q.size() != 0) chk("load_snr", snr_idx, exp_q[0].snr);

        if (res_valid) begin
          if (!valid_prev) rr_wait = (hold >= 0) ? hold : int'($urandom % 4);
          if (exp_q.size() == 0) begin
            chk("extra_result", res_valid, 0);
          end else begin
            chk("res_snr",    res_snr,    exp_q[0].snr);
            chk("res_frames", res_frames, exp_q[0].frames);
            chk("res_errs",   res_errs,   exp_q[0].errs);
          end
          chk("no_load_in_report", llr_load, 0);
          if (rr_wait == 0) begin
            res_ready = 1'b1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            xfer_prev = 1'b1;
          end else begin
            res_ready = 1'b0;
            rr_wait--;
          end
        end else begin
          res_ready = bit'($urandom % 2);
        end
        valid_prev = res_valid;

        if (llr_load) begin
          n_load++;
          dec_pend = 1'b1;
          dec_wait = int'($urandom % 4);
        end else if (dec_pend && dec_en) begin
          if (rst_at != 0 && n_load == rst_at) begin
            rst    = 1'b1;
            in_rst = 1'b1;
          end else if (dec_wait == 0) begin
            term      = 1'b1;
            frame_err = pat[k];
            k++;
            dec_pend  = 1'b0;
            term_prev = 1'b1;
          end else begin
            dec_wait--;
          end
        end else if (!dec_en && ($urandom % 8) == 0) begin
          term = 1'b1;
        end

        @(negedge clk);
      end
    end

    drive_quiet();
    chk("results_left", exp_q.size(), 0);
    chk("end_done", done, 1);
  endtask

`ifdef BER_WATCHDOG_EN
  task automatic wdt_test();
    int dr = 0;
    int cyc = 0;
    @(negedge clk);
    drive_quiet();
    snr_first   = 4'd5;
    snr_last    = 4'd5;
    max_frames  = 16'd2;
    min_errs    = 12'd100;
    frame_ready = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!res_valid && cyc < 500) begin
      if (dec_en && dec_rst) dr++;
      cyc++;
      @(negedge clk);
    end
    chk("wdt_valid",  res_valid,  1);
    chk("wdt_snr",    res_snr,    5);
    chk("wdt_frames", res_frames, 2);
    chk("wdt_errs",   res_errs,   2);
    chk("wdt_pulses", dr,         2);
    chk("wdt_tmo_cnt", tmo_cnt,   2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("wdt_done", done, 1);
  endtask
`endif

  initial begin
    int f, l, mf, me;
    rst        = 1'b1;
    snr_first  = '0;
    snr_last   = '0;
    max_frames = '0;
    min_errs   = '0;
    hold_flag  = 1'b1;
    drive_quiet();
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_dec_rst", dec_rst, 1);
    chk("idle_busy", busy, 0);

    run_sweep(10, 10, 4, 100, 0, -1, 0);   // single point, frame limit
    run_sweep(2, 4, 100, 2, 1, -1, 0);     // error target, three points
    run_sweep(7, 8, 3, 5, 2, 50, 0);       // long res_ready stall
    run_sweep(1, 3, 4, 10, 2, -1, 3);      // reset during third decode
    run_sweep(1, 3, 4, 10, 2, -1, 0);      // clean restart
    run_sweep(9, 4, 3, 2, 2, -1, 0);       // first > last
    run_sweep(6, 6, 0, 5, 2, -1, 0);       // max_frames 0 acts as 1
    run_sweep(15, 15, 2, 0, 2, -1, 0);     // top SNR, zero error target

    for (int n = 0; n < 10; n++) begin
      f = int'($urandom % 16);
      if (($urandom % 4) == 0) begin
        l = (f == 0) ? 0 : int'($urandom % f);
      end else begin
        l = f + int'($urandom % 3);
        if (l > 15) l = 15;
      end
      mf = int'($urandom % 6);
      me = int'($urandom % 5);
      run_sweep(f, l, mf, me, 2, -1, 0);
    end

`ifdef BER_WATCHDOG_EN
    wdt_test();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ber_sweep_ctrl.md
BER_SWEEP_CTRL -- requirements
Module: ber_sweep_ctrl

Interface
REQ-001 Parameters: SNR_W=4 (SNR index width), FRM_W=16 (frame counter width), ERR_W=12 (error counter width), SETTLE_CYC=16 (flush cycles after SNR change), TMO_CYC=4096 (decode watchdog limit).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins a sweep, ignored unless in IDLE or DONE.
REQ-005 snr_first, snr_last  in  SNR_W  sweep bounds, inclusive; sampled at start.
REQ-006 max_frames  in  FRM_W  frame limit per SNR point; sampled at start.
REQ-007 min_errs  in  ERR_W  frame-error target per SNR point; sampled at start.
REQ-008 frame_ready  in  1  all noise/LLR buffers full (AND of buffer-full flags).
REQ-009 term, frame_err  in  1  decoder done; decoder frame in error (valid only with term).
REQ-010 snr_idx  out  SNR_W  SNR index driven to all quantizers.
REQ-011 buf_flush  out  1  clears all LLR buffers.
REQ-012 llr_load  out  1  one-cycle strobe; capture buffer contents into decoder input register.
REQ-013 dec_rst, dec_en  out  1  decoder reset and enable.
REQ-014 res_valid  out  1; res_ready  in  1; res_snr  out  SNR_W; res_frames  out  FRM_W; res_errs  out  ERR_W: per-SNR result handshake.
REQ-015 busy, done  out  1  sweep in progress; sweep complete.

Function
REQ-016 States: IDLE, SETTLE, FILL, LOAD, DECODE, REPORT, DONE.
REQ-017 IDLE/DONE + start -> SETTLE; snr_idx<=snr_first; clear frame and error counters; done<=0.
REQ-018 SETTLE: buf_flush=1 for exactly SETTLE_CYC cycles, then -> FILL.
REQ-019 FILL: wait for frame_ready=1 -> LOAD.
REQ-020 LOAD: one cycle; llr_load=1, dec_rst=1, buf_flush=1 (buffers refill during decode) -> DECODE.
REQ-021 DECODE: dec_en=1 until term; when term=1: frames+1, and errs+1 if frame_err; dec_en=0 in the following cycle.
REQ-022 After term, if frames==max_frames or errs>=min_errs (evaluated on the updated counts) -> REPORT, else -> FILL.
REQ-023 REPORT: res_valid=1 with res_snr/res_frames/res_errs held stable until res_ready=1 in the same cycle; the transfer completes in that cycle.
REQ-024 After the transfer: if snr_idx==snr_last -> DONE, else snr_idx+1, clear counters -> SETTLE.
REQ-025 snr_first>snr_last: sweep ends after the single point snr_first.
REQ-026 max_frames==0 is treated as 1.
REQ-027 Counters saturate at all-ones, never wrap; saturation of frames forces REPORT.
REQ-028 term outside DECODE is ignored; start outside IDLE/DONE is ignored.
REQ-029 busy=1 in all states except IDLE and DONE; done=1 only in DONE.
REQ-030 A term that coincides with frame_ready is counted normally; frame_ready is then evaluated in FILL on the next cycle.

Reset
REQ-031 rst has priority over all inputs: state<=IDLE; snr_idx, counters, res_* <=0; res_valid, llr_load, buf_flush, dec_en, busy, done <=0; dec_rst<=1.
REQ-032 rst asserted mid-DECODE or mid-REPORT discards the in-flight frame and any unaccepted result.
REQ-033 After rst deasserts, dec_rst stays 1 until the first LOAD.

Configuration
REQ-034 Macro BER_WATCHDOG_EN compiled in: in DECODE, a cycle counter counts cycles without term. At TMO_CYC it pulses dec_rst for one cycle and counts the frame as erroneous (frames+1, errs+1), then applies REQ-022. Output tmo_cnt (ERR_W, saturating) counts these events; its reset value is 0.
REQ-035 BER_WATCHDOG_EN not defined: no watchdog logic and no tmo_cnt port; DECODE waits on term indefinitely.

Verification
REQ-036 snr_first=10, snr_last=10, max_frames=4, min_errs=100, four terms with frame_err=0 -> one result {snr=10, frames=4, errs=0}, then done=1.
REQ-037 snr 2..4, min_errs=2, frame_err=1 on every term -> three results, each with frames=2 and errs=2; snr_idx sequence 2,3,4; SETTLE lasts 16 cycles before each point.
REQ-038 res_ready held low 50 cycles in REPORT -> res_* stable, no new llr_load, and progress resumes one cycle after res_ready=1.
REQ-039 rst pulse during DECODE of frame 3 -> all outputs at reset values next cycle, dec_rst=1; a new start restarts from snr_first with cleared counters.
REQ-040 BER_WATCHDOG_EN defined, TMO_CYC=8, term never asserted, max_frames=2 -> two timeouts, result {frames=2, errs=2}, tmo_cnt=2.
